dac_interp_upsampler: RTL and testbench
=======================================

Name: dac_interp_upsampler

Overview:
Upstream feeder for the sigma-delta DAC modulator. Accepts signed PCM samples at a low rate over a valid/ready handshake and buffers them in a small FIFO. Produces a linearly interpolated BW-bit signed sample on every modulator clock, with 2**OSR_LOG2 clocks per input sample. The output connects directly to the modulator's dac_i, which removes the zero-order-hold images in front of the modulator.

Parameters:
BW, 16, sample width (signed two's complement); must match the modulator BW.
OSR_LOG2, 5, log2 of clocks per input sample (OSR = 32).
FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.

Ports:
clk  input  1  modulator clock; all logic on posedge.
rst_n_i  input  1  reset, asynchronous and active-low.
s_data_i  input  BW  signed input sample.
s_valid_i  input  1  s_data_i valid.
s_ready_o  output  1  FIFO can accept; equals !fifo_full.
dac_o  output  BW  signed interpolated sample, to modulator dac_i.
underrun_o  output  1  one-cycle pulse when the FIFO is empty at a period end.
active_o  output  1  high in RUN or HOLD state.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - FIFO flushed.
  - acc, diff, phase and the "b" register cleared.
  - State = IDLE.
  - dac_o = 0, underrun_o = 0, active_o = 0; s_ready_o = 1 once reset is released.
  - Reset asserted mid-ramp takes effect immediately; there is no ramp-down.
- Handshake: a transfer occurs on a posedge with s_valid_i and s_ready_o both high. The sample is written into the FIFO at that edge. There is no bypass path.
- FIFO push and pop in the same cycle are allowed. When full, s_ready_o = 0. Pop from empty never occurs.
- Datapath (no multiplier):
  - diff: signed BW+1 bits, equal to new − b.
  - acc: signed BW+OSR_LOG2+1 bits, holding the value << OSR_LOG2.
  - dac_o = (acc >>> OSR_LOG2) truncated to BW bits, taken directly from the register with no combinational path.
  - After OSR additions of diff, acc equals b << OSR_LOG2 exactly. The result is monotonic between endpoints and never overflows BW.
- State machine:
  - IDLE: acc = 0. On an edge with the FIFO non-empty: pop, b = sample, diff = sample − 0, phase = 0, go to RUN.
  - RUN: each edge, acc += diff and phase++. On the edge where phase == OSR−1 (acc lands on b):
    - FIFO non-empty: pop new, diff = new − b, b = new, phase = 0, stay in RUN.
    - FIFO empty: diff = 0, go to HOLD, underrun_o = 1 for the next cycle.
  - HOLD: acc frozen, so dac_o holds b. On an edge with the FIFO non-empty: pop, diff = new − b, b = new, phase = 0, go to RUN.
  - HOLD never returns to IDLE; only reset does that.
- Latency: sample accepted at edge N → FIFO written at N → popped at N+1 (if the state allows a pop) → dac_o first moves at N+2.
- Throughput: one sample per OSR clocks sustained. The FIFO absorbs upstream jitter of up to FIFO_DEPTH samples.
- Extremes: −2**(BW−1) → 2**(BW−1)−1 gives diff = 2**BW − 1, which fits in BW+1 bits.

Decomposition:
- Shared package dac_pkg holds:
  - default BW and OSR_LOG2 constants;
  - state encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2.
- One natural sub-module: dac_sample_fifo, a synchronous FIFO parameterised by width and depth. It has push/pop ports, full/empty flags, a level output, and asynchronous active-low reset.
- Interpolator, FSM and counters stay in the top module.

Test Plan:
1. Reset, then push 1024 once (OSR_LOG2 = 5). dac_o = 0 until N+2, then 32, 64, … each clock; reaches 1024 after 32 steps; underrun_o pulses once; dac_o holds 1024 and active_o = 1.
2. Stream 1024 then −1024 back-to-back while keeping the FIFO fed. dac_o ramps up to 1024, then down by 64 per clock to −1024; no underrun_o; exactly 32 clocks per segment.
3. Extremes: push −32768 then 32767. The ramp is monotonic, with no wrap; the endpoints are hit exactly; dac_o never exceeds the range.
4. Push 6 samples back-to-back with s_valid_i held high. s_ready_o drops when 4 entries are buffered; no sample is lost or duplicated; output endpoints match the input order.
5. Underrun recovery: let HOLD persist 50 clocks, then push 0. The new ramp starts at the next edge after the FIFO write and goes from b to 0 in 32 clocks.
6. Drop rst_n_i asynchronously mid-ramp (between clock edges). dac_o = 0 immediately; FIFO empty; s_ready_o = 1 after release; the state returns to IDLE.

Source files
------------

// File: rtl/dac_pkg.sv
// dac_pkg: shared defaults and FSM state encoding for the DAC interpolating upsampler
//   DAC_BW       default sample width, must match the modulator
//   DAC_OSR_LOG2 default log2 of modulator clocks per input sample
//   ST_*         interpolator FSM state encoding
package dac_pkg;
    localparam int DAC_BW       = 16;
    localparam int DAC_OSR_LOG2 = 5;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: synchronous first-word-fall-through sample FIFO
//   clk      clock, all state on posedge
//   rst_n    asynchronous active-low reset, flushes the FIFO
//   push     write wr_data (ignored when full)
//   wr_data  sample to write
//   pop      drop the head entry (ignored when empty)
//   rd_data  head entry, valid whenever empty is low
//   full     DEPTH entries held
//   empty    no entries held
//   level    number of entries held
module dac_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/dac_interp_upsampler.sv
// dac_interp_upsampler: buffers PCM samples and emits a linearly interpolated sample every clock
//   clk         modulator clock, all logic on posedge
//   rst_n_i     asynchronous active-low reset
//   s_data_i    signed input sample
//   s_valid_i   s_data_i valid
//   s_ready_o   FIFO can accept a sample
//   dac_o       signed interpolated sample for the modulator
//   underrun_o  one-cycle pulse when a ramp ends with the FIFO empty
//   active_o    interpolator is ramping or holding
module dac_interp_upsampler
    import dac_pkg::*;
#(
    parameter int BW         = DAC_BW,
    parameter int OSR_LOG2   = DAC_OSR_LOG2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n_i,
    input  logic [BW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [BW-1:0] dac_o,
    output logic          underrun_o,
    output logic          active_o
);
    localparam int ACC_W = BW + OSR_LOG2 + 1;
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    logic [1:0]              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [BW:0]      diff, new_diff;
    logic signed [BW-1:0]    b, head;
    logic [OSR_LOG2-1:0]     phase;
    logic                    fifo_full, fifo_empty, pop, at_end, underrun;
    logic [LW-1:0]           fifo_level;
    logic                    unused_level;
    dac_sample_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n_i),
        .push    (s_valid_i),
        .wr_data (s_data_i),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );
    assign unused_level = ^fifo_level;
    // the last step of a ramp lands acc exactly on b << OSR_LOG2
    assign at_end     = state == ST_RUN && phase == '1;
    assign pop        = !fifo_empty && (state != ST_RUN || at_end);
    // b is zero in IDLE, so this also gives the first ramp from zero
    assign new_diff   = (BW+1)'(head) - (BW+1)'(b);
    assign s_ready_o  = !fifo_full;
    assign dac_o      = acc[BW+OSR_LOG2-1:OSR_LOG2];
    assign underrun_o = underrun;
    assign active_o   = state == ST_RUN || state == ST_HOLD;
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_IDLE;
            acc      <= '0;
            diff     <= '0;
            b        <= '0;
            phase    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                ST_RUN: begin
                    acc   <= acc + ACC_W'(diff);
                    phase <= phase + 1'b1;
                    if (at_end && pop) begin
                        diff  <= new_diff;
                        b     <= head;
                        phase <= '0;
                    end else if (at_end) begin
                        diff     <= '0;
                        state    <= ST_HOLD;
                        underrun <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (pop) begin
                        diff  <= new_diff;
                        b     <= head;
                        phase <= '0;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    acc <= '0;
                    if (pop) begin
                        diff  <= new_diff;
                        b     <= head;
                        phase <= '0;
                        state <= ST_RUN;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_interp_upsampler.sv
// tb_dac_interp_upsampler: scoreboard bench with a timing/arithmetic reference model
module tb_dac_interp_upsampler;
    localparam int BW    = 16;
    localparam int OSR   = 32;
    localparam int DEPTH = 4;

    typedef struct {
        int at;
        int val;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n_i = 1'b1;
    logic                 s_valid_i = 1'b0;
    logic signed [BW-1:0] s_data_i = '0;
    logic                 s_ready_o, underrun_o, active_o;
    logic signed [BW-1:0] dac_o;

    exp_t exp_q[$];
    int   wr_edge[$];
    int   pop_edge[$];
    int   smp[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   last_val = 0;
    bit   in_reset = 1'b1;

    dac_interp_upsampler #(
        .BW         (BW),
        .OSR_LOG2   (5),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n_i    (rst_n_i),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .dac_o      (dac_o),
        .underrun_o (underrun_o),
        .active_o   (active_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, int got, int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    // straight line from a to b over OSR steps, rounded toward minus infinity
    function automatic int interp(int a, int b, int j);
        int num;
        int q;
        num = a * OSR + j * (b - a);
        q = num / OSR;
        if (num % OSR != 0 && num < 0) q--;
        return q;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // sample v enters the FIFO at edge w; it is consumed once available and the previous ramp is done
    task automatic record(int w, int v);
        int k;
        int a;
        int p;
        k = wr_edge.size();
        a = (k > 0) ? smp[k-1] : 0;
        p = w + 1;
        if (k > 0 && pop_edge[k-1] + OSR > p) p = pop_edge[k-1] + OSR;
        wr_edge.push_back(w);
        pop_edge.push_back(p);
        smp.push_back(v);
        for (int j = 1; j <= OSR; j++) exp_q.push_back('{p + j, interp(a, v, j)});
    endtask

    task automatic send(int v);
        int waited;
        waited = 0;
        @(negedge clk);
        s_valid_i = 1'b1;
        s_data_i  = BW'(v);
        while (!s_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready_o) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout at cycle %0d: got s_ready_o=0, expected 1 within 200 cycles", cyc);
            s_valid_i = 1'b0;
        end else begin
            record(cyc + 1, v);
        end
    endtask

    task automatic idle(int n);
        @(negedge clk);
        s_valid_i = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_model();
        exp_q.delete();
        wr_edge.delete();
        pop_edge.delete();
        smp.delete();
        last_val = 0;
    endtask

    // monitor: every cycle compare all outputs against the model
    initial begin
        int  e;
        int  occ;
        bit  exp_und;
        bit  exp_act;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                e = cyc;
                if (exp_q.size() > 0 && exp_q[0].at == e) begin
                    last_val = exp_q[0].val;
                    void'(exp_q.pop_front());
                end
                occ = 0;
                exp_und = 1'b0;
                exp_act = pop_edge.size() > 0 && pop_edge[0] <= e;
                for (int k = 0; k < wr_edge.size(); k++) if (wr_edge[k] <= e) occ++;
                for (int k = 0; k < pop_edge.size(); k++) begin
                    if (pop_edge[k] <= e) occ--;
                    if (pop_edge[k] + OSR == e && (k + 1 >= wr_edge.size() || wr_edge[k+1] >= e)) exp_und = 1'b1;
                end
                check("dac_o", int'(dac_o), last_val);
                check("underrun_o", int'(underrun_o), int'(exp_und));
                check("active_o", int'(active_o), int'(exp_act));
                check("s_ready_o", int'(s_ready_o), int'(occ < DEPTH));
            end
        end
    end

    initial begin
        #1 rst_n_i = 1'b0;
        #2;
        check("reset_dac_o", int'(dac_o), 0);
        check("reset_active_o", int'(active_o), 0);
        check("reset_underrun_o", int'(underrun_o), 0);
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1 in_reset = 1'b0;
        repeat (4) @(posedge clk);
        // single sample: ramp, underrun, hold
        send(1024);
        idle(50);
        // back-to-back opposite ramps
        send(-1024);
        send(1024);
        send(-1024);
        idle(120);
        // full-scale extremes
        send(-32768);
        send(32767);
        send(-32768);
        idle(120);
        // burst of six with valid held high fills the FIFO
        repeat (6) send(rnd());
        idle(220);
        // long hold then recovery
        idle(50);
        send(0);
        idle(40);
        // random stream with random gaps
        repeat (25) begin
            send(rnd());
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 60)));
        end
        idle(1);
        // asynchronous reset in the middle of a ramp
        send(rnd());
        idle(10);
        @(posedge clk);
        #2 rst_n_i = 1'b0;
        in_reset = 1'b1;
        #1;
        check("midreset_dac_o", int'(dac_o), 0);
        check("midreset_active_o", int'(active_o), 0);
        check("midreset_underrun_o", int'(underrun_o), 0);
        clear_model();
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1 in_reset = 1'b0;
        repeat (3) @(posedge clk);
        repeat (4) send(rnd());
        idle(150);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
